// File: rtl/pad_round_controller.sv
// Round sequencer for the pad-hitting game: lamp select, hit/miss judging, score and screen control.
// Optional PAD_TIMEOUT_EN enables the lit-pad timeout; without it LIT waits for a pad edge.
module pad_round_controller #(
  parameter int NUM_PADS       = 8,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int MAX_MISTAKES   = 3,
  parameter int SCORE_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_PADS-1:0] pads,
  output logic [2:0]          light_sel,
  output logic                light_on,
  output logic [SCORE_W-1:0]  score,
  output logic [3:0]          mistakes,
  output logic [1:0]          screen,
  output logic                screen_change,
  output logic                mistake_pulse
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {SPLASH, GAP, LIT, OVER} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [2:0]          target_n;
  logic [SCORE_W-1:0]  score_n;
  logic [3:0]          mistakes_n;
  logic [1:0]          screen_n;
  logic                screen_change_n, mistake_pulse_n;
  logic [15:0]         lfsr;
  logic [NUM_PADS:0]   sync1, sync2, sync3, rise;
  logic                start_edge, mistake, timeout;
  logic [NUM_PADS-1:0] pad_edge, target_mask;
  logic [2:0]          cand;

  // Edge pulse is registered, so an input sampled at edge k acts at edge k+3.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      rise  <= '0;
    end else begin
      sync1 <= {start, pads};
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

  assign start_edge  = rise[NUM_PADS];
  assign pad_edge    = rise[NUM_PADS-1:0];
  assign target_mask = NUM_PADS'(1) << light_sel;
  assign cand        = lfsr[2:0];

  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

`ifdef PAD_TIMEOUT_EN
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    target_n        = light_sel;
    score_n         = score;
    mistakes_n      = mistakes;
    screen_n        = screen;
    screen_change_n = 1'b0;
    mistake_pulse_n = 1'b0;
    mistake         = 1'b0;
    case (state)
      SPLASH: begin
        if (start_edge) begin
          score_n         = '0;
          mistakes_n      = '0;
          cnt_n           = '0;
          state_n         = GAP;
          screen_n        = 2'd1;
          screen_change_n = 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          // Never light the same pad twice in a row.
          target_n = (cand == light_sel) ? cand + 3'd1 : cand;
          cnt_n    = '0;
          state_n  = LIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LIT: begin
        if (|(pad_edge & target_mask)) begin
          if (score != '1) score_n = score + 1'b1;
          cnt_n   = '0;
          state_n = GAP;
        end else if (|(pad_edge & ~target_mask)) begin
          mistake = 1'b1;
        end else if (timeout) begin
          mistake = 1'b1;
        end else begin
`ifdef PAD_TIMEOUT_EN
          cnt_n = cnt + 1'b1;
`endif
        end
        if (mistake) begin
          mistakes_n      = mistakes + 4'd1;
          mistake_pulse_n = 1'b1;
          cnt_n           = '0;
          if (mistakes_n == 4'(MAX_MISTAKES)) begin
            state_n         = OVER;
            screen_n        = 2'd2;
            screen_change_n = 1'b1;
          end else begin
            state_n = GAP;
          end
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n         = SPLASH;
          screen_n        = 2'd0;
          screen_change_n = 1'b1;
        end
      end
      default: state_n = SPLASH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= SPLASH;
      cnt           <= '0;
      light_sel     <= '0;
      light_on      <= 1'b0;
      score         <= '0;
      mistakes      <= '0;
      screen        <= 2'd0;
      screen_change <= 1'b0;
      mistake_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      light_sel     <= target_n;
      light_on      <= (state_n == LIT);
      score         <= score_n;
      mistakes      <= mistakes_n;
      screen        <= screen_n;
      screen_change <= screen_change_n;
      mistake_pulse <= mistake_pulse_n;
    end
  end

endmodule

// File: tb/tb_pad_round_controller.sv
// Randomized bench for pad_round_controller against a cycle-counting game model.
module tb_pad_round_controller;
  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int MAXM = 3;
  localparam int SW   = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    pads  = '0;
  logic [2:0]    light_sel;
  logic          light_on;
  logic [SW-1:0] score;
  logic [3:0]    mistakes;
  logic [1:0]    screen;
  logic          screen_change;
  logic          mistake_pulse;

  pad_round_controller #(
    .NUM_PADS(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_MISTAKES(MAXM), .SCORE_W(SW)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .pads(pads),
    .light_sel(light_sel), .light_on(light_on), .score(score), .mistakes(mistakes),
    .screen(screen), .screen_change(screen_change), .mistake_pulse(mistake_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int sc_count = 0, mp_count = 0;
  int exp_score = 0, exp_mistakes = 0;
  logic [2:0]  prev_tgt = '0, cur_tgt = '0;
  logic [15:0] m_lfsr = 16'hACE1;

  // Reference LFSR: arithmetic form of the 16,14,13,11 Fibonacci register.
  always @(posedge clock) begin
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
  end

  always @(negedge clock) begin
    if (screen_change) sc_count++;
    if (mistake_pulse) mp_count++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called right after GAP entry; ends right after LIT entry with cur_tgt predicted.
  task automatic predict_round(input int noise);
    logic [2:0] cand;
    if (noise >= 0) pads[noise] = 1'b1;
    step(1);
    if (noise >= 0) pads[noise] = 1'b0;
    step(GAP - 2);
    cand = m_lfsr[2:0];
    cur_tgt = (cand == prev_tgt) ? cand + 3'd1 : cand;
    prev_tgt = cur_tgt;
    step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0; step(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(5);
    checks++; if (light_on !== 1'b0) begin errors++; $display("FAIL rst_light_on: got %0d expected 0", light_on); end
    checks++; if (light_sel !== 3'd0) begin errors++; $display("FAIL rst_light_sel: got %0d expected 0", light_sel); end
    checks++; if (score !== '0) begin errors++; $display("FAIL rst_score: got %0d expected 0", score); end
    checks++; if (mistakes !== 4'd0) begin errors++; $display("FAIL rst_mistakes: got %0d expected 0", mistakes); end
    checks++; if (screen !== 2'd0) begin errors++; $display("FAIL rst_screen: got %0d expected 0", screen); end
    checks++; if ({screen_change, mistake_pulse} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b expected 00", {screen_change, mistake_pulse}); end
    checks++; if (u_dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL rst_lfsr: got %h expected ace1", u_dut.lfsr); end
    reset = 1'b0;
    step(1);
    checks++; if (u_dut.lfsr !== 16'h5670) begin errors++; $display("FAIL lfsr_first_step: got %h expected 5670", u_dut.lfsr); end
    step(2);
    checks++; if (u_dut.lfsr !== m_lfsr) begin errors++; $display("FAIL lfsr_track: got %h expected %h", u_dut.lfsr, m_lfsr); end
    prev_tgt = '0; exp_score = 0; exp_mistakes = 0;
  endtask

  task automatic test_start_and_hit();
    int d;
    logic [2:0] held;
    start = 1'b1; step(1); start = 1'b0; step(2);
    checks++; if (screen !== 2'd0) begin errors++; $display("FAIL start_latency: got screen %0d expected 0", screen); end
    step(1);
    checks++; if ({screen, screen_change} !== 3'b011) begin errors++; $display("FAIL start_screen: got %b expected 011", {screen, screen_change}); end
    predict_round(-1);
    checks++; if (sc_count !== 1) begin errors++; $display("FAIL start_pulse_count: got %0d expected 1", sc_count); end
    checks++; if ({light_on, light_sel} !== {1'b1, cur_tgt}) begin errors++; $display("FAIL lit1: got %b expected %b", {light_on, light_sel}, {1'b1, cur_tgt}); end
    pulse_start();
    checks++; if ({screen, light_on} !== 3'b011 || sc_count !== 1) begin errors++; $display("FAIL start_midgame: got screen %0d lit %0d pulses %0d expected 1 1 1", screen, light_on, sc_count); end
    d = $urandom_range(0, 4);
    if (d > 0) step(d);
    held = cur_tgt;
    pads[held] = 1'b1;
    step(3);
    checks++; if ({light_on, score} !== {1'b1, SW'(0)}) begin errors++; $display("FAIL hit_latency: got lit %0d score %0d expected 1 0", light_on, score); end
    step(1);
    exp_score = 1;
    checks++; if ({light_on, score} !== {1'b0, SW'(exp_score)}) begin errors++; $display("FAIL hit1: got lit %0d score %0d expected 0 %0d", light_on, score, exp_score); end
    predict_round(-1);
    checks++; if ({light_on, light_sel} !== {1'b1, cur_tgt}) begin errors++; $display("FAIL lit2: got %b expected %b", {light_on, light_sel}, {1'b1, cur_tgt}); end
    step(6);
    checks++; if ({light_on, score, mistakes} !== {1'b1, SW'(exp_score), 4'd0}) begin errors++; $display("FAIL held_pad: got lit %0d score %0d mistakes %0d expected 1 %0d 0", light_on, score, mistakes, exp_score); end
    pads[held] = 1'b0;
    pads[cur_tgt] = 1'b1; step(1); pads[cur_tgt] = 1'b0; step(3);
    exp_score = 2;
    checks++; if ({light_on, score} !== {1'b0, SW'(exp_score)}) begin errors++; $display("FAIL hit2: got lit %0d score %0d expected 0 %0d", light_on, score, exp_score); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] wrong;
    predict_round(int'($urandom_range(0, 7)));
    checks++; if ({light_on, light_sel, mistakes} !== {1'b1, cur_tgt, 4'd0} || mp_count !== 0) begin errors++; $display("FAIL gap_noise: got lit %0d sel %0d mistakes %0d pulses %0d expected 1 %0d 0 0", light_on, light_sel, mistakes, mp_count, cur_tgt); end
    wrong = cur_tgt + 3'($urandom_range(1, 7));
    pads = (8'd1 << cur_tgt) | (8'd1 << wrong);
    step(1); pads = '0; step(3);
    exp_score++;
    checks++; if ({light_on, score, mistakes, mistake_pulse} !== {1'b0, SW'(exp_score), 4'd0, 1'b0}) begin errors++; $display("FAIL both_pads: got lit %0d score %0d mistakes %0d pulse %0d expected 0 %0d 0 0", light_on, score, mistakes, mistake_pulse, exp_score); end
    predict_round(-1);
    checks++; if ({light_on, light_sel} !== {1'b1, cur_tgt}) begin errors++; $display("FAIL lit3: got %b expected %b", {light_on, light_sel}, {1'b1, cur_tgt}); end
    wrong = cur_tgt + 3'($urandom_range(1, 7));
    pads[wrong] = 1'b1; step(1); pads[wrong] = 1'b0; step(3);
    exp_mistakes = 1;
    checks++; if ({light_on, mistakes, mistake_pulse, score} !== {1'b0, 4'd1, 1'b1, SW'(exp_score)}) begin errors++; $display("FAIL wrong_pad: got lit %0d mistakes %0d pulse %0d score %0d expected 0 1 1 %0d", light_on, mistakes, mistake_pulse, score, exp_score); end
  endtask

`ifdef PAD_TIMEOUT_EN
  task automatic test_timeout();
    while (exp_mistakes < MAXM) begin
      predict_round(-1);
      checks++; if ({light_on, light_sel} !== {1'b1, cur_tgt}) begin errors++; $display("FAIL tmo_lit: got %b expected %b", {light_on, light_sel}, {1'b1, cur_tgt}); end
      step(TMO - 1);
      checks++; if (light_on !== 1'b1) begin errors++; $display("FAIL tmo_early: got lit %0d expected 1", light_on); end
      step(1);
      exp_mistakes++;
      checks++; if ({light_on, mistake_pulse, mistakes} !== {1'b0, 1'b1, 4'(exp_mistakes)}) begin errors++; $display("FAIL tmo_miss: got lit %0d pulse %0d mistakes %0d expected 0 1 %0d", light_on, mistake_pulse, mistakes, exp_mistakes); end
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [2:0] wrong;
    predict_round(-1);
    step(1000);
    checks++; if ({light_on, light_sel, mistakes} !== {1'b1, cur_tgt, 4'd1} || mp_count !== 1) begin errors++; $display("FAIL idle_lit: got lit %0d sel %0d mistakes %0d pulses %0d expected 1 %0d 1 1", light_on, light_sel, mistakes, mp_count, cur_tgt); end
    for (int r = 0; exp_mistakes < MAXM; r++) begin
      if (r > 0) predict_round(-1);
      wrong = cur_tgt + 3'($urandom_range(1, 7));
      pads[wrong] = 1'b1; step(1); pads[wrong] = 1'b0; step(3);
      exp_mistakes++;
      checks++; if ({light_on, mistake_pulse, mistakes} !== {1'b0, 1'b1, 4'(exp_mistakes)}) begin errors++; $display("FAIL wrong_miss: got lit %0d pulse %0d mistakes %0d expected 0 1 %0d", light_on, mistake_pulse, mistakes, exp_mistakes); end
    end
  endtask
`endif

  task automatic test_over_restart();
    checks++; if ({screen, screen_change} !== 3'b101) begin errors++; $display("FAIL over_screen: got %b expected 101", {screen, screen_change}); end
    step(20);
    checks++; if ({screen, light_on, score, mistakes} !== {2'd2, 1'b0, SW'(exp_score), 4'(MAXM)}) begin errors++; $display("FAIL over_hold: got screen %0d lit %0d score %0d mistakes %0d expected 2 0 %0d %0d", screen, light_on, score, mistakes, exp_score, MAXM); end
    checks++; if (sc_count !== 2 || mp_count !== MAXM) begin errors++; $display("FAIL over_pulses: got sc %0d mp %0d expected 2 %0d", sc_count, mp_count, MAXM); end
    pulse_start();
    checks++; if ({screen, screen_change, score} !== {2'd0, 1'b1, SW'(exp_score)}) begin errors++; $display("FAIL restart: got screen %0d pulse %0d score %0d expected 0 1 %0d", screen, screen_change, score, exp_score); end
  endtask

  task automatic test_saturation();
    int d, noise;
    pulse_start();
    exp_score = 0; exp_mistakes = 0;
    checks++; if ({screen, score, mistakes} !== {2'd1, SW'(0), 4'd0}) begin errors++; $display("FAIL new_game: got screen %0d score %0d mistakes %0d expected 1 0 0", screen, score, mistakes); end
    for (int i = 0; i < (1 << SW) + 1; i++) begin
      noise = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      predict_round(noise);
      checks++; if ({light_on, light_sel} !== {1'b1, cur_tgt}) begin errors++; $display("FAIL sat_lit: got %b expected %b", {light_on, light_sel}, {1'b1, cur_tgt}); end
      d = $urandom_range(0, 4);
      if (d > 0) step(d);
      pads[cur_tgt] = 1'b1; step(1); pads[cur_tgt] = 1'b0; step(3);
      if (exp_score < (1 << SW) - 1) exp_score++;
      checks++; if (score !== SW'(exp_score)) begin errors++; $display("FAIL sat_score: got %0d expected %0d", score, exp_score); end
    end
    checks++; if (score !== '1) begin errors++; $display("FAIL saturated: got %0d expected all ones", score); end
  endtask

  task automatic test_mid_reset();
    predict_round(-1);
    reset = 1'b1; step(1);
    checks++; if ({light_on, light_sel, score, mistakes, screen} !== {1'b0, 3'd0, SW'(0), 4'd0, 2'd0}) begin errors++; $display("FAIL mid_reset: got lit %0d sel %0d score %0d mistakes %0d screen %0d expected all 0", light_on, light_sel, score, mistakes, screen); end
    reset = 1'b0; prev_tgt = '0;
    pulse_start();
    predict_round(-1);
    checks++; if ({screen, light_on, light_sel} !== {2'd1, 1'b1, cur_tgt}) begin errors++; $display("FAIL post_reset_round: got %b expected %b", {screen, light_on, light_sel}, {2'd1, 1'b1, cur_tgt}); end
  endtask

  initial begin
    test_reset();
    test_start_and_hit();
    test_simultaneous();
`ifdef PAD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_over_restart();
    test_saturation();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1);
  end
endmodule
